// File: rtl/instr_fifo_buffer.sv
// instr_fifo_buffer
//   Circular instruction buffer with first-word fall-through head, registered
//   look-ahead (peek) port, synchronous flush and sticky overflow flag.
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   flush              synchronous discard of all entries (beats push/pop)
//   in_valid/ready     producer handshake, in_data = word to write
//   out_valid/ready    consumer handshake, out_data = head word (0 when empty)
//   peek_index         offset from head; peek_data/peek_valid are 1 cycle later
//   count, full, empty occupancy status
//   ovf_sticky         push attempted while full; cleared by rst or flush
module instr_fifo_buffer #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_data,
  input  logic [$clog2(DEPTH)-1:0]   peek_index,
  output logic [WORD_W-1:0]          peek_data,
  output logic                       peek_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_sticky
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] peek_data_q, peek_data_d;
  logic              peek_valid_q, peek_valid_d;
  logic              ovf_q, ovf_d;

  logic              push, pop, peek_hit;
  logic [PTR_W-1:0]  peek_addr;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign in_ready  = !full;          // no write-through when full
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rp_q];
  assign count     = cnt_q;
  assign peek_data = peek_data_q;
  assign peek_valid = peek_valid_q;
  assign ovf_sticky = ovf_q;

  assign push = in_valid && !full;
  assign pop  = out_valid && out_ready;   // empty => no pop, even if pushing

  // PTR_W-bit add wraps modulo DEPTH since DEPTH is a power of two.
  assign peek_addr = rp_q + peek_index;
  assign peek_hit  = ({1'b0, peek_index} < cnt_q);

  always_comb begin
    wp_d         = wp_q;
    rp_d         = rp_q;
    cnt_d        = cnt_q;
    peek_valid_d = peek_hit;
    peek_data_d  = peek_hit ? mem_q[peek_addr] : '0;
    ovf_d        = ovf_q | (in_valid & full);
    if (push) wp_d = wp_q + PTR_W'(1);
    if (pop)  rp_d = rp_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      wp_d         = '0;
      rp_d         = '0;
      cnt_d        = '0;
      peek_valid_d = 1'b0;
      peek_data_d  = '0;
      ovf_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
      peek_data_q  <= '0;
      peek_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      cnt_q        <= cnt_d;
      peek_data_q  <= peek_data_d;
      peek_valid_q <= peek_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage is never reset; it is only visible through live entries.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wp_q] <= in_data;
  end

endmodule

// File: tb/tb_instr_fifo_buffer.sv
module tb_instr_fifo_buffer;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic              in_ready, out_valid, peek_valid, full, empty, ovf_sticky;
  logic [WORD_W-1:0] in_data, out_data, peek_data;
  logic [3:0]        peek_index;
  logic [4:0]        count;

  int n_vec = 0;
  int n_err = 0;

  instr_fifo_buffer #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .peek_index(peek_index), .peek_data(peek_data), .peek_valid(peek_valid),
    .count(count), .full(full), .empty(empty), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
  endtask

  initial begin
    int pushn, popn;
    rst = 1; peek_index = '0;
    idle();
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_peek_valid", peek_valid, 0);
    chk("rst_ovf", ovf_sticky, 0);
    step();
    rst = 0;
    step();

    // fill / drain
    in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'h1000_0000 + i;
      step();
    end
    idle();
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 16);
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 32'h1000_0000 + i);
      step();
    end
    idle();
    chk("drain_empty", empty, 1);
    chk("drain_out_data", out_data, 0);

    // wrap with concurrent push/pop
    pushn = 0; popn = 0;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h2000_0000 + pushn; pushn++;
      step();
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      chk("w_pop_data", out_data, 32'h2000_0000 + popn); popn++;
      step();
    end
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h2000_0000 + pushn; pushn++;
      step();
    end
    chk("w_count8", count, 8);
    out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      chk("w_conc_data", out_data, 32'h2000_0000 + popn); popn++;
      in_data = 32'h2000_0000 + pushn; pushn++;
      step();
      chk("w_conc_count", count, 8);
    end
    in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk("w_tail_data", out_data, 32'h2000_0000 + popn); popn++;
      step();
    end
    idle();
    chk("w_empty", empty, 1);

    // overflow
    in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'h3000_0000 + i;
      step();
    end
    in_data = 32'hDEAD_BEEF;
    step();
    chk("ovf_count", count, 16);
    chk("ovf_sticky", ovf_sticky, 1);
    chk("ovf_head", out_data, 32'h3000_0000);
    out_ready = 1;                    // push while full must not write through
    step();
    idle();
    chk("ovf_nowt_count", count, 15);
    chk("ovf_nowt_head", out_data, 32'h3000_0001);
    flush = 1;
    step();
    idle();
    chk("flush_count", count, 0);
    chk("flush_ovf", ovf_sticky, 0);
    chk("flush_out_valid", out_valid, 0);

    // peek: A,B,C,D
    in_valid = 1;
    in_data = 32'hAAAA_0001; step();
    in_data = 32'hBBBB_0002; step();
    in_data = 32'hCCCC_0003; step();
    in_data = 32'hDDDD_0004; step();
    idle();
    peek_index = 2; step();
    chk("peek2_data", peek_data, 32'hCCCC_0003);
    chk("peek2_valid", peek_valid, 1);
    peek_index = 3; step();
    chk("peek3_data", peek_data, 32'hDDDD_0004);
    chk("peek3_valid", peek_valid, 1);
    peek_index = 4; step();
    chk("peek4_valid", peek_valid, 0);
    peek_index = 5; step();
    chk("peek5_valid", peek_valid, 0);
    chk("peek5_data", peek_data, 0);
    peek_index = 0;

    // flush priority at count 3
    out_ready = 1; step(); idle();
    chk("fp_count3", count, 3);
    flush = 1; in_valid = 1; out_ready = 1; in_data = 32'h0000_0077;
    step();
    idle();
    chk("fp_count0", count, 0);
    chk("fp_empty", empty, 1);
    in_valid = 1; in_data = 32'h0000_0088; step(); idle();
    chk("fp_next_head", out_data, 32'h0000_0088);
    chk("fp_next_count", count, 1);

    // async reset mid-stream at count 7
    flush = 1; step(); idle();
    in_valid = 1;
    for (int i = 0; i < 7; i++) begin
      in_data = 32'h4000_0000 + i;
      step();
    end
    idle();
    chk("ar_count7", count, 7);
    #2 rst = 1;
    #1;
    chk("ar_count0", count, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    #1 rst = 0;
    step();
    in_valid = 1; in_data = 32'h0000_0055; step(); idle();
    chk("ar_push55", out_data, 32'h0000_0055);
    chk("ar_count1", count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
